fma_issue_ctrl: RTL and testbench

- Issue controller that shares one fixed-latency single-precision FMA datapath (multiplier, normaliser, rounder) between two requesters.
- Arbitrates requests round-robin and resolves dynamic rounding mode against the frm CSR.
- Tracks in-flight ops with a valid/tag shift pipeline, buffers results in a credit-protected response FIFO and accumulates sticky fflags.
- Sits between the FP issue stage and the FMA datapath.

---
 rtl/fma_ctrl_pkg.sv | 40 ++++
 rtl/fma_rsp_fifo.sv | 54 +++++
 rtl/fma_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fma_issue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_ctrl_pkg.sv
// Shared encodings and record types for the FMA issue controller and its response FIFO.
package fma_ctrl_pkg;

    localparam int XLEN_W = 32;
    localparam int TAG_W  = 4;
    localparam int RM_W   = 3;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef struct packed {
        logic             valid;
        logic             illegal;
        logic             id;
        logic [TAG_W-1:0] tag;
    } slot_t;

    typedef struct packed {
        logic [XLEN_W-1:0] result;
        logic [4:0]        flags;
        logic              illegal;
        logic              id;
        logic [TAG_W-1:0]  tag;
    } rsp_t;

    function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
        return (rm == RM_DYN) ? frm : rm;
    endfunction

endpackage

// File: rtl/fma_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; head entry is read straight from storage.
module fma_rsp_fifo
    import fma_ctrl_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
)(
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  pop_data_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_push    = push_i && (count != CW'(DEPTH));
    assign do_pop     = pop_i && (count != '0);
    assign pop_data_o = mem[rd_ptr];
    assign count_o    = count;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fma_issue_ctrl.sv
// Round-robin issue controller sharing one fixed-latency FMA datapath between two requesters.
// Optional perf counters are built only when FMA_ISSUE_CTRL_PERF_EN is defined.
module fma_issue_ctrl
    import fma_ctrl_pkg::*;
#(
    parameter int PARM_XLEN       = XLEN_W,
    parameter int PARM_LAT        = 4,
    parameter int PARM_FIFO_DEPTH = 4,
    parameter int PARM_TAG        = TAG_W,
    parameter int PARM_RM         = RM_W
)(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   Req0_valid_i,
    output logic                   Req0_ready_o,
    input  logic [3*PARM_XLEN-1:0] Req0_ops_i,
    input  logic [PARM_RM-1:0]     Req0_rm_i,
    input  logic [PARM_TAG-1:0]    Req0_tag_i,
    input  logic                   Req1_valid_i,
    output logic                   Req1_ready_o,
    input  logic [3*PARM_XLEN-1:0] Req1_ops_i,
    input  logic [PARM_RM-1:0]     Req1_rm_i,
    input  logic [PARM_TAG-1:0]    Req1_tag_i,
    input  logic [PARM_RM-1:0]     Frm_i,
    output logic                   Dp_valid_o,
    output logic [3*PARM_XLEN-1:0] Dp_ops_o,
    output logic [PARM_RM-1:0]     Dp_rm_o,
    input  logic [PARM_XLEN-1:0]   Dp_result_i,
    input  logic [3:0]             Dp_flags_i,
    output logic                   Rsp_valid_o,
    input  logic                   Rsp_ready_i,
    output logic [PARM_XLEN-1:0]   Rsp_result_o,
    output logic [4:0]             Rsp_flags_o,
    output logic                   Rsp_illegal_o,
    output logic                   Rsp_id_o,
    output logic [PARM_TAG-1:0]    Rsp_tag_o,
    output logic [4:0]             Fflags_o,
    input  logic                   Fflags_clr_i
`ifdef FMA_ISSUE_CTRL_PERF_EN
    ,
    output logic [31:0]            Perf_issue_o,
    output logic [31:0]            Perf_stall_o
`endif
);

    localparam int CW = $clog2(PARM_FIFO_DEPTH + 1);
    localparam int RW = $bits(rsp_t);

    logic               can_issue, grant0, grant1, issue, win_id, op_illegal, pop;
    logic               rr_last;
    logic [CW-1:0]      cnt, fifo_cnt;
    logic [PARM_RM-1:0] res_rm;
    slot_t              pipe [PARM_LAT];
    slot_t              new_slot, exit_slot;
    rsp_t               push_ent, rsp_ent;

    // Ready is held low while reset is asserted so nothing is granted into a clearing pipe.
    always_comb begin
        can_issue  = rst_n_i && (cnt < CW'(PARM_FIFO_DEPTH));
        grant0     = can_issue && Req0_valid_i && (!Req1_valid_i || rr_last);
        grant1     = can_issue && Req1_valid_i && (!Req0_valid_i || !rr_last);
        issue      = grant0 || grant1;
        win_id     = grant1;
        res_rm     = resolve_rm(win_id ? Req1_rm_i : Req0_rm_i, Frm_i);
        op_illegal = (res_rm > RM_RMM);
    end

    always_comb begin
        Req0_ready_o = grant0;
        Req1_ready_o = grant1;
        Dp_valid_o   = issue && !op_illegal;
        Dp_ops_o     = win_id ? Req1_ops_i : Req0_ops_i;
        Dp_rm_o      = res_rm;
    end

    always_comb begin
        new_slot.valid   = issue;
        new_slot.illegal = issue && op_illegal;
        new_slot.id      = win_id;
        new_slot.tag     = win_id ? Req1_tag_i : Req0_tag_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < PARM_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= new_slot;
            for (int i = 1; i < PARM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign exit_slot = pipe[PARM_LAT-1];

    // Datapath outputs are only trusted for legal ops that were actually launched.
    always_comb begin
        push_ent         = '0;
        push_ent.illegal = exit_slot.illegal;
        push_ent.id      = exit_slot.id;
        push_ent.tag     = exit_slot.tag;
        if (exit_slot.valid && !exit_slot.illegal) begin
            push_ent.result       = Dp_result_i;
            push_ent.flags[FF_NV] = Dp_flags_i[3];
            push_ent.flags[FF_OF] = Dp_flags_i[2];
            push_ent.flags[FF_UF] = Dp_flags_i[1];
            push_ent.flags[FF_NX] = Dp_flags_i[0];
        end
    end

    fma_rsp_fifo #(
        .W     (RW),
        .DEPTH (PARM_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (exit_slot.valid),
        .push_data_i (push_ent),
        .pop_i       (pop),
        .pop_data_o  (rsp_ent),
        .count_o     (fifo_cnt)
    );

    always_comb begin
        Rsp_valid_o   = (fifo_cnt != '0);
        pop           = Rsp_valid_o && Rsp_ready_i;
        Rsp_result_o  = rsp_ent.result;
        Rsp_flags_o   = rsp_ent.flags;
        Rsp_illegal_o = rsp_ent.illegal;
        Rsp_id_o      = rsp_ent.id;
        Rsp_tag_o     = rsp_ent.tag;
    end

    // rr_last = requester granted most recently; reset value gives Req0 priority.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt      <= '0;
            rr_last  <= 1'b1;
            Fflags_o <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (issue) rr_last <= win_id;
            if (pop && !rsp_ent.illegal)
                Fflags_o <= (Fflags_clr_i ? 5'b0 : Fflags_o) | rsp_ent.flags;
            else if (Fflags_clr_i)
                Fflags_o <= '0;
        end
    end

`ifdef FMA_ISSUE_CTRL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            Perf_issue_o <= '0;
            Perf_stall_o <= '0;
        end else begin
            if (issue) Perf_issue_o <= Perf_issue_o + 32'd1;
            if ((Req0_valid_i || Req1_valid_i) && !issue) Perf_stall_o <= Perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Directed bench for fma_issue_ctrl: single-op vector table plus arbitration, credit, flag and reset sequences.
module tb_fma_issue_ctrl;

    localparam int XL    = 32;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int RMW   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            Req0_valid_i, Req1_valid_i, Req0_ready_o, Req1_ready_o;
    logic [3*XL-1:0] Req0_ops_i, Req1_ops_i, Dp_ops_o;
    logic [RMW-1:0]  Req0_rm_i, Req1_rm_i, Frm_i, Dp_rm_o;
    logic [TW-1:0]   Req0_tag_i, Req1_tag_i, Rsp_tag_o;
    logic            Dp_valid_o;
    logic [XL-1:0]   Dp_result_i, Rsp_result_o;
    logic [3:0]      Dp_flags_i;
    logic            Rsp_valid_o, Rsp_ready_i, Rsp_illegal_o, Rsp_id_o;
    logic [4:0]      Rsp_flags_o, Fflags_o;
    logic            Fflags_clr_i;
`ifdef FMA_ISSUE_CTRL_PERF_EN
    logic [31:0]     Perf_issue_o, Perf_stall_o;
`endif

    fma_issue_ctrl #(
        .PARM_XLEN(XL), .PARM_LAT(LAT), .PARM_FIFO_DEPTH(DEPTH), .PARM_TAG(TW), .PARM_RM(RMW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .Req0_valid_i(Req0_valid_i), .Req0_ready_o(Req0_ready_o), .Req0_ops_i(Req0_ops_i),
        .Req0_rm_i(Req0_rm_i), .Req0_tag_i(Req0_tag_i),
        .Req1_valid_i(Req1_valid_i), .Req1_ready_o(Req1_ready_o), .Req1_ops_i(Req1_ops_i),
        .Req1_rm_i(Req1_rm_i), .Req1_tag_i(Req1_tag_i),
        .Frm_i(Frm_i),
        .Dp_valid_o(Dp_valid_o), .Dp_ops_o(Dp_ops_o), .Dp_rm_o(Dp_rm_o),
        .Dp_result_i(Dp_result_i), .Dp_flags_i(Dp_flags_i),
        .Rsp_valid_o(Rsp_valid_o), .Rsp_ready_i(Rsp_ready_i), .Rsp_result_o(Rsp_result_o),
        .Rsp_flags_o(Rsp_flags_o), .Rsp_illegal_o(Rsp_illegal_o), .Rsp_id_o(Rsp_id_o),
        .Rsp_tag_o(Rsp_tag_o), .Fflags_o(Fflags_o), .Fflags_clr_i(Fflags_clr_i)
`ifdef FMA_ISSUE_CTRL_PERF_EN
        , .Perf_issue_o(Perf_issue_o), .Perf_stall_o(Perf_stall_o)
`endif
    );

    // Datapath stand-in: result = A^B^C, flags = C[3:0], returned LAT cycles after the issue cycle.
    logic [XL-1:0] dl_res [LAT];
    logic [3:0]    dl_flg [LAT];
    always @(posedge clk) begin
        dl_res[0] <= Dp_ops_o[3*XL-1:2*XL] ^ Dp_ops_o[2*XL-1:XL] ^ Dp_ops_o[XL-1:0];
        dl_flg[0] <= Dp_ops_o[3:0];
        for (int i = 1; i < LAT; i++) begin
            dl_res[i] <= dl_res[i-1];
            dl_flg[i] <= dl_flg[i-1];
        end
    end
    assign Dp_result_i = dl_res[LAT-1];
    assign Dp_flags_i  = dl_flg[LAT-1];

    typedef struct {
        logic          id;
        logic [2:0]    rm;
        logic [2:0]    frm;
        logic [TW-1:0] tag;
        logic [31:0]   a, b, c;
        logic          exp_dpv;
        logic [2:0]    exp_rm;
        logic          exp_ill;
        logic [31:0]   exp_res;
        logic [4:0]    exp_flags;
        logic [4:0]    exp_ff;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        Req0_valid_i = 1'b0;
        Req1_valid_i = 1'b0;
        Rsp_ready_i  = 1'b1;
        repeat (15) @(negedge clk);
        Rsp_ready_i  = 1'b0;
    endtask

    // One isolated op: issue checks, latency, response fields, then handshake and accrued flags.
    task automatic run_op(input vec_t v, input string nm, input logic clr_at_hs);
        int k;
        @(negedge clk);
        Frm_i = v.frm;
        if (v.id == 1'b0) begin
            Req0_valid_i = 1'b1; Req0_ops_i = {v.a, v.b, v.c}; Req0_rm_i = v.rm; Req0_tag_i = v.tag;
        end else begin
            Req1_valid_i = 1'b1; Req1_ops_i = {v.a, v.b, v.c}; Req1_rm_i = v.rm; Req1_tag_i = v.tag;
        end
        #1;
        chk($sformatf("%s ready", nm), v.id ? Req1_ready_o : Req0_ready_o, 1);
        chk($sformatf("%s dp_valid", nm), Dp_valid_o, v.exp_dpv);
        chk($sformatf("%s dp_rm", nm), Dp_rm_o, v.exp_rm);
        if (v.exp_dpv) chk($sformatf("%s dp_ops", nm), Dp_ops_o, {v.a, v.b, v.c});
        @(negedge clk);
        Req0_valid_i = 1'b0;
        Req1_valid_i = 1'b0;
        k = 1;
        while (!Rsp_valid_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("%s latency", nm), k, LAT + 1);
        chk($sformatf("%s rsp_result", nm), Rsp_result_o, v.exp_res);
        chk($sformatf("%s rsp_flags", nm), Rsp_flags_o, v.exp_flags);
        chk($sformatf("%s rsp_illegal", nm), Rsp_illegal_o, v.exp_ill);
        chk($sformatf("%s rsp_id", nm), Rsp_id_o, v.id);
        chk($sformatf("%s rsp_tag", nm), Rsp_tag_o, v.tag);
        Rsp_ready_i  = 1'b1;
        Fflags_clr_i = clr_at_hs;
        @(negedge clk);
        Rsp_ready_i  = 1'b0;
        Fflags_clr_i = 1'b0;
        chk($sformatf("%s fflags", nm), Fflags_o, v.exp_ff);
        chk($sformatf("%s rsp_empty", nm), Rsp_valid_o, 0);
    endtask

    vec_t vecs [7];
    vec_t vf0, vf1, vr;
    int   gids [6];
    int   rids [6];
    int   rtags [6];
    int   ng, nr, both, stale, sum;

    initial begin
        //            id    rm      frm     tag    a             b             c             dpv   rm      ill   res           flags     ff
        vecs[0] = '{1'b0, 3'b000, 3'b000, 4'h5, 32'h00001000, 32'h00000200, 32'h00000031, 1'b1, 3'b000, 1'b0, 32'h00001231, 5'b00001, 5'b00001};
        vecs[1] = '{1'b1, 3'b001, 3'b000, 4'hA, 32'h00FF0000, 32'h0000FF00, 32'h00000004, 1'b1, 3'b001, 1'b0, 32'h00FFFF04, 5'b00100, 5'b00101};
        vecs[2] = '{1'b0, 3'b111, 3'b011, 4'h3, 32'h00000000, 32'h00000000, 32'h00000008, 1'b1, 3'b011, 1'b0, 32'h00000008, 5'b10000, 5'b10101};
        vecs[3] = '{1'b1, 3'b111, 3'b101, 4'h7, 32'h12345678, 32'h00000000, 32'h0000000F, 1'b0, 3'b101, 1'b1, 32'h00000000, 5'b00000, 5'b10101};
        vecs[4] = '{1'b0, 3'b110, 3'b000, 4'h9, 32'h00000000, 32'h00000000, 32'h00000002, 1'b0, 3'b110, 1'b1, 32'h00000000, 5'b00000, 5'b10101};
        vecs[5] = '{1'b1, 3'b100, 3'b111, 4'hF, 32'h00000001, 32'h00000010, 32'h00000102, 1'b1, 3'b100, 1'b0, 32'h00000113, 5'b00010, 5'b10111};
        vecs[6] = '{1'b0, 3'b111, 3'b111, 4'h0, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 3'b111, 1'b1, 32'h00000000, 5'b00000, 5'b10111};
        vf0     = '{1'b0, 3'b000, 3'b000, 4'h1, 32'h00000000, 32'h00000000, 32'h00000004, 1'b1, 3'b000, 1'b0, 32'h00000004, 5'b00100, 5'b00100};
        vf1     = '{1'b1, 3'b000, 3'b000, 4'h2, 32'h00000000, 32'h00000000, 32'h00000002, 1'b1, 3'b000, 1'b0, 32'h00000002, 5'b00010, 5'b00010};
        vr      = '{1'b0, 3'b010, 3'b000, 4'h6, 32'hA0000000, 32'h0B000000, 32'h00000001, 1'b1, 3'b010, 1'b0, 32'hAB000001, 5'b00001, 5'b00001};

        rst_n = 1'b0;
        Req0_valid_i = 1'b1; Req1_valid_i = 1'b0;
        Req0_ops_i = '0; Req1_ops_i = '0; Req0_rm_i = '0; Req1_rm_i = '0;
        Req0_tag_i = '0; Req1_tag_i = '0; Frm_i = '0;
        Rsp_ready_i = 1'b0; Fflags_clr_i = 1'b0;

        @(negedge clk);
        #1;
        chk("reset rsp_valid", Rsp_valid_o, 0);
        chk("reset fflags", Fflags_o, 0);
        chk("reset dp_valid", Dp_valid_o, 0);
        chk("reset req0_ready", Req0_ready_o, 0);
        Req0_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // Clear alone, accrue one flag, then clear together with a handshake.
        @(negedge clk);
        Fflags_clr_i = 1'b1;
        @(negedge clk);
        Fflags_clr_i = 1'b0;
        chk("clr_alone fflags", Fflags_o, 0);
        run_op(vf0, "ff_of", 1'b0);
        run_op(vf1, "ff_clr_hs", 1'b1);

        // Both requesters contending from reset: grants and responses alternate starting at Req0.
        do_reset();
        Req0_tag_i = 4'h0; Req1_tag_i = 4'h1;
        Req0_rm_i = 3'b000; Req1_rm_i = 3'b000; Frm_i = 3'b000;
        Rsp_ready_i = 1'b1;
        ng = 0; nr = 0; both = 0;
        for (int c = 0; c < 60 && (ng < 6 || nr < 6); c++) begin
            @(negedge clk);
            Req0_valid_i = (ng < 6);
            Req1_valid_i = (ng < 6);
            #1;
            if (Rsp_valid_o && nr < 6) begin
                rids[nr]  = Rsp_id_o;
                rtags[nr] = Rsp_tag_o;
                nr++;
            end
            if (Req0_ready_o && Req1_ready_o) both++;
            if (Req0_ready_o && ng < 6) begin gids[ng] = 0; ng++; end
            else if (Req1_ready_o && ng < 6) begin gids[ng] = 1; ng++; end
        end
        Req0_valid_i = 1'b0; Req1_valid_i = 1'b0;
        chk("rr grant count", ng, 6);
        chk("rr rsp count", nr, 6);
        chk("rr double grant", both, 0);
        for (int i = 0; i < 6; i++) begin
            if (i < ng) chk($sformatf("rr grant%0d", i), gids[i], i % 2);
            if (i < nr) chk($sformatf("rr rsp_id%0d", i), rids[i], i % 2);
            if (i < nr) chk($sformatf("rr rsp_tag%0d", i), rtags[i], i % 2);
        end
        drain();

        // Credit exhaustion with the consumer stalled.
        Rsp_ready_i = 1'b0;
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            Req0_tag_i   = TW'(ng);
            Req0_valid_i = 1'b1;
            #1;
            if (Req0_ready_o) ng++;
        end
        Req1_valid_i = 1'b1;
        #1;
        chk("credit issue count", ng, DEPTH);
        chk("credit req0_ready", Req0_ready_o, 0);
        chk("credit req1_ready", Req1_ready_o, 0);
        chk("credit head tag", Rsp_tag_o, 0);
        @(negedge clk);
        Rsp_ready_i = 1'b1;
        #1;
        sum = int'(Req0_ready_o) + int'(Req1_ready_o);
        chk("credit no bypass", sum, 0);
        @(negedge clk);
        Rsp_ready_i = 1'b0;
        #1;
        sum = int'(Req0_ready_o) + int'(Req1_ready_o);
        chk("credit refill grant", sum, 1);
        chk("credit next head tag", Rsp_tag_o, 1);
        @(negedge clk);
        #1;
        sum = int'(Req0_ready_o) + int'(Req1_ready_o);
        chk("credit full again", sum, 0);
        drain();

        // Reset with ops both in flight and queued.
        Rsp_ready_i = 1'b0;
        ng = 0;
        for (int c = 0; c < 10 && ng < 4; c++) begin
            @(negedge clk);
            Req0_tag_i   = TW'(8 + ng);
            Req0_valid_i = 1'b1;
            #1;
            if (Req0_ready_o) ng++;
        end
        repeat (3) @(negedge clk);
        chk("pre-reset rsp_valid", Rsp_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("async reset rsp_valid", Rsp_valid_o, 0);
        chk("async reset req0_ready", Req0_ready_o, 0);
        chk("async reset dp_valid", Dp_valid_o, 0);
        Req0_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        Rsp_ready_i = 1'b1;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (Rsp_valid_o) stale++;
        end
        Rsp_ready_i = 1'b0;
        chk("post-reset stale rsp", stale, 0);
        run_op(vr, "post_reset", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
